// File: rtl/fetch_stage.sv
// Fetch stage: takes PCs from pre-fetch, waits on ICache when needed,
// and queues finished or exception-tagged entries in order for decode.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  exccode;
    logic        tlb_refill;
    logic [31:0] badvaddr;
  } fs_entry_t;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int DROP_MAX    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pfs_to_valid,
  output logic        fs_allowin,
  input  logic        pfs_inst_valid,
  input  logic [31:0] pfs_inst,
  input  logic [31:0] pfs_pc,
  input  logic        pfs_ex,
  input  logic [4:0]  pfs_exccode,
  input  logic        pfs_tlb_refill,
  input  logic        icache_data_ok,
  input  logic [31:0] icache_rdata,
  input  logic        inst_tlb_ex,
  input  logic        inst_tlb_refill,
  input  logic [4:0]  inst_tlb_exccode,
  input  logic        flush,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_inst,
  output logic [31:0] fs_pc,
  output logic        fs_ex,
  output logic [4:0]  fs_exccode,
  output logic        fs_tlb_refill,
  output logic [31:0] fs_badvaddr
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_n;
  logic [31:0] pend_pc, pend_n;
  logic [1:0]  drop_cnt, drop_n;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  fs_entry_t   q [QUEUE_DEPTH];
  fs_entry_t   enq_e, hd;
  logic        enq, accept, pop;
  logic        stale, d_inc, d_dec;

  assign stale  = icache_data_ok & (drop_cnt != 2'd0);
  assign fs_allowin = (state == IDLE)
                    & (count < CW'(QUEUE_DEPTH))
                    & (drop_cnt < 2'(DROP_MAX));
  assign accept = pfs_to_valid & fs_allowin & ~flush;
  assign fs_to_ds_valid = (count != '0);
  assign pop    = fs_to_ds_valid & ds_allowin & ~flush;

  // Next state, pending PC and the entry to enqueue.
  always_comb begin
    state_n = state;
    pend_n  = pend_pc;
    enq     = 1'b0;
    enq_e   = '0;
    if (flush) begin
      state_n = IDLE;
      pend_n  = '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          if (pfs_inst_valid | pfs_ex) begin
            enq              = 1'b1;
            enq_e.inst       = pfs_ex ? 32'd0 : pfs_inst;
            enq_e.pc         = pfs_pc;
            enq_e.ex         = pfs_ex;
            enq_e.exccode    = pfs_exccode;
            enq_e.tlb_refill = pfs_tlb_refill;
            enq_e.badvaddr   = pfs_pc;
          end else begin
            pend_n  = pfs_pc;
            state_n = WAIT;
          end
        end
        WAIT: if (icache_data_ok & ~stale) begin
          enq              = 1'b1;
          enq_e.inst       = icache_rdata;
          enq_e.pc         = pend_pc;
          enq_e.ex         = inst_tlb_ex;
          enq_e.exccode    = inst_tlb_exccode;
          enq_e.tlb_refill = inst_tlb_refill;
          enq_e.badvaddr   = pend_pc;
          state_n          = IDLE;
        end
      endcase
    end
  end

  // A flush in WAIT orphans the in-flight request unless its
  // response is arriving right now; stale responses retire one each.
  always_comb begin
    d_inc  = flush & (state == WAIT) & ~(icache_data_ok & ~stale);
    d_dec  = stale;
    drop_n = drop_cnt;
    if (d_inc & ~d_dec)
      drop_n = (drop_cnt == 2'(DROP_MAX)) ? drop_cnt : drop_cnt + 2'd1;
    else if (d_dec & ~d_inc)
      drop_n = drop_cnt - 2'd1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pend_pc  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      pend_pc  <= pend_n;
      drop_cnt <= drop_n;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  // Queue storage; contents are only visible through the valid head.
  always_ff @(posedge clk) begin
    if (enq) q[tail] <= enq_e;
  end

  assign hd = fs_to_ds_valid ? q[head] : '0;

  assign fs_inst       = hd.inst;
  assign fs_pc         = hd.pc;
  assign fs_ex         = hd.ex;
  assign fs_exccode    = hd.exccode;
  assign fs_tlb_refill = hd.tlb_refill;
  assign fs_badvaddr   = hd.badvaddr;

endmodule
